// File: rtl/pipeline_stage_chain_if.sv
// Valid/ready handshake bundle for pipeline_stage_chain: producer side (in_*) and consumer side (out_*).
// The chain itself uses the slave view; whatever drives it uses the master view.
interface pipeline_stage_chain_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipeline_stage_chain.sv
// Elastic STAGES-deep register chain with per-stage valid bits, bubble collapse and synchronous flush.
// Optional skid entry before stage 0 (breaks the out_ready->in_ready path): `define PIPELINE_STAGE_CHAIN_SKID_EN.
module pipeline_stage_chain #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STAGES    = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  localparam int unsigned     CW        = $clog2(STAGES + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_stage_chain_if.slave bus,
  input  logic                  flush,
  output logic [CW-1:0]         occupancy
);
  logic [STAGES-1:0] v_reg;
  logic [WIDTH-1:0]  d_reg [STAGES];
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_d [STAGES];
  logic [CW-1:0]     occ_reg;
  logic              in_xfer;
  logic              out_xfer;

  assign bus.out_valid = v_reg[STAGES-1];
  assign bus.out_data  = d_reg[STAGES-1];
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign out_xfer      = bus.out_valid && bus.out_ready;
  assign occupancy     = occ_reg;

  // Stage i can load iff some stage at or ahead of it is empty, or the head is draining.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      assign load[gi] = bus.out_ready || !(&v_reg[STAGES-1:gi]);
      if (gi > 0) begin : g_link
        assign src_v[gi] = v_reg[gi-1];
        assign src_d[gi] = d_reg[gi-1];
      end
    end
  endgenerate

`ifdef PIPELINE_STAGE_CHAIN_SKID_EN
  logic             skid_v_reg;
  logic [WIDTH-1:0] skid_d_reg;

  assign bus.in_ready = !rst && !flush && !skid_v_reg;
  assign src_v[0]     = skid_v_reg || in_xfer;
  assign src_d[0]     = skid_v_reg ? skid_d_reg : bus.in_data;

  // The skid holds one accepted payload while stage 0 is stalled; it always drains before new input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_v_reg <= 1'b0;
      skid_d_reg <= NOP_VALUE;
    end else if (flush) begin
      skid_v_reg <= 1'b0;
      skid_d_reg <= NOP_VALUE;
    end else if (skid_v_reg) begin
      if (load[0]) begin
        skid_v_reg <= 1'b0;
      end
    end else if (in_xfer && !load[0]) begin
      skid_v_reg <= 1'b1;
      skid_d_reg <= bus.in_data;
    end
  end
`else
  assign bus.in_ready = !rst && !flush && load[0];
  assign src_v[0]     = in_xfer;
  assign src_d[0]     = bus.in_data;
`endif

  // Data is only captured from a valid source, so a bubble leaves the old payload in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_reg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d_reg[i] <= NOP_VALUE;
      end
    end else if (flush) begin
      v_reg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d_reg[i] <= NOP_VALUE;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          v_reg[i] <= src_v[i];
          if (src_v[i]) begin
            d_reg[i] <= src_d[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg <= '0;
    end else if (flush) begin
      occ_reg <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   occ_reg <= occ_reg + CW'(1);
        2'b01:   occ_reg <= occ_reg - CW'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end
endmodule
